prim_fifo_unpack: RTL and testbench

PRIM_FIFO_UNPACK -- requirements
Module: prim_fifo_unpack

---
 rtl/prim_fifo_unpack.sv | 213 +++++++++++++++++++++
 tb/tb_prim_fifo_unpack.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_fifo_unpack.sv
//-----------------------------------------------------------------------------
// prim_fifo_unpack
//
// Purpose:
//   Sits on the read port of a FIFO whose words are InW bits wide and hands
//   the word out as a stream of OutW-bit chunks, least-significant chunk
//   first. A per-word mask marks how many leading chunks of the word carry
//   data. A word whose mask is not of the form 2^n-1 (n >= 1) is dropped and
//   flagged with a one-cycle error pulse. At most one word is held; when the
//   final chunk of a word is taken, the next word may be loaded in the same
//   cycle, so full-rate streaming has no bubbles.
//
// Handshakes:
//   Both the input side (valid_i/ready_o) and the output side
//   (valid_o/ready_i) transfer exactly on a clock edge where valid and ready
//   are both high. A valid, once raised, holds its payload stable until the
//   transfer happens. ready_o depends combinationally on ready_i (so that the
//   final chunk and the next word can move in the same cycle); valid_o never
//   depends on ready_i.
//
// Parameters:
//   InW   - input word width (read width of the upstream FIFO)
//   OutW  - output chunk width; InW must be an integer multiple of OutW
//
// Ports:
//   clk_i    in   1      clock
//   rst_ni   in   1      asynchronous active-low reset
//   clr_i    in   1      synchronous flush of the held word
//   valid_i  in   1      input word valid
//   ready_o  out  1      input word accepted
//   data_i   in   InW    input word
//   mask_i   in   Ratio  chunk mask, bit k qualifies data_i[k*OutW +: OutW]
//   valid_o  out  1      chunk valid
//   ready_i  in   1      chunk consumed
//   data_o   out  OutW   current chunk
//   last_o   out  1      current chunk is the last one of its word
//   cnt_o    out  CntW   chunks remaining in the held word
//   err_o    out  1      one-cycle pulse after an illegal mask was accepted
//   idle_o   out  1      no word held
//-----------------------------------------------------------------------------
module prim_fifo_unpack #(
    parameter int InW  = 32,
    parameter int OutW = 8,
    localparam int Ratio = InW / OutW,
    // Counter must represent 0..Ratio inclusive.
    localparam int CntW  = $clog2(Ratio + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,

    input  logic             valid_i,
    output logic             ready_o,
    input  logic [InW-1:0]   data_i,
    input  logic [Ratio-1:0] mask_i,

    output logic             valid_o,
    input  logic             ready_i,
    output logic [OutW-1:0]  data_o,
    output logic             last_o,
    output logic [CntW-1:0]  cnt_o,
    output logic             err_o,
    output logic             idle_o
);

    //-------------------------------------------------------------------------
    // Elaboration-time parameter check
    //-------------------------------------------------------------------------
    if (OutW < 1 || InW < OutW || (InW % OutW) != 0) begin : g_bad_param
        $error("prim_fifo_unpack: InW (%0d) must be a nonzero multiple of OutW (%0d)",
               InW, OutW);
    end

    //-------------------------------------------------------------------------
    // State
    //-------------------------------------------------------------------------
    logic             r_under_rst;  // high from reset until first clock edge after release
    logic [InW-1:0]   r_data_q;     // held word, current chunk in the low OutW bits
    logic [CntW-1:0]  r_cnt_q;      // chunks still to emit; 0 means empty
    logic             r_err_q;      // registered illegal-mask pulse

    //-------------------------------------------------------------------------
    // Combinational signals
    //-------------------------------------------------------------------------
    logic             w_empty;
    logic             w_cnt_one;
    logic             w_accept;
    logic             w_out_hs;
    logic [Ratio-1:0] w_mask_inc;
    logic             w_mask_legal;
    logic [CntW-1:0]  w_popcnt;
    logic [InW-1:0]   w_data_shift;

    logic [InW-1:0]   w_data_d;
    logic [CntW-1:0]  w_cnt_d;
    logic             w_err_d;

    assign w_empty   = (r_cnt_q == '0);
    assign w_cnt_one = (r_cnt_q == CntW'(1));

    // A word may enter when nothing is held, or when the last chunk of the
    // held word leaves in this same cycle.
    assign ready_o  = ~r_under_rst & ~clr_i & (w_empty | (w_cnt_one & ready_i));
    assign valid_o  = ~w_empty & ~r_under_rst;

    assign w_accept = valid_i & ready_o;
    assign w_out_hs = valid_o & ready_i;

    // Legal masks are 2^n-1: adding one to such a mask clears every set bit,
    // so the AND with the incremented value is zero. Zero itself is excluded.
    // The increment wraps within Ratio bits, which keeps the all-ones mask legal.
    assign w_mask_inc   = mask_i + Ratio'(1);
    assign w_mask_legal = (|mask_i) & ~(|(mask_i & w_mask_inc));

    // Number of chunks in a legal word. Only used when the mask is legal, in
    // which case it equals n for the mask 2^n-1.
    always_comb begin
        w_popcnt = '0;
        for (int k = 0; k < Ratio; k++) begin
            w_popcnt = w_popcnt + CntW'(mask_i[k]);
        end
    end

    // Held word advanced by one chunk, zero-filled from the top. With a
    // single chunk per word there is nothing left after the shift.
    if (Ratio == 1) begin : g_shift_single
        assign w_data_shift = '0;
    end else begin : g_shift_multi
        assign w_data_shift = {{OutW{1'b0}}, r_data_q[InW-1:OutW]};
    end

    //-------------------------------------------------------------------------
    // Next-state: flush beats load, load beats shift. A load in the cycle
    // the final chunk leaves replaces the word outright, so no shift is
    // needed in that case.
    //-------------------------------------------------------------------------
    always_comb begin
        w_data_d = r_data_q;
        w_cnt_d  = r_cnt_q;
        w_err_d  = 1'b0;

        if (clr_i) begin
            w_data_d = '0;
            w_cnt_d  = '0;
        end else if (w_accept) begin
            if (w_mask_legal) begin
                w_data_d = data_i;
                w_cnt_d  = w_popcnt;
            end else begin
                // Drop the word; any chunk handed out this cycle was the
                // final one, so the block ends up empty either way.
                w_data_d = '0;
                w_cnt_d  = '0;
                w_err_d  = 1'b1;
            end
        end else if (w_out_hs) begin
            w_data_d = w_data_shift;
            w_cnt_d  = r_cnt_q - CntW'(1);
        end
    end

    //-------------------------------------------------------------------------
    // Registers
    //-------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_under_rst <= 1'b1;
            r_data_q    <= '0;
            r_cnt_q     <= '0;
            r_err_q     <= 1'b0;
        end else begin
            r_under_rst <= 1'b0;
            r_data_q    <= w_data_d;
            r_cnt_q     <= w_cnt_d;
            r_err_q     <= w_err_d;
        end
    end

    //-------------------------------------------------------------------------
    // Outputs
    //-------------------------------------------------------------------------
    assign data_o = r_data_q[OutW-1:0];
    assign last_o = valid_o & w_cnt_one;
    assign cnt_o  = r_cnt_q;
    assign err_o  = r_err_q;
    assign idle_o = w_empty;

    //-------------------------------------------------------------------------
    // Properties
    //-------------------------------------------------------------------------
    // A stalled chunk must not change under the consumer.
    property p_out_stable;
        @(posedge clk_i) disable iff (!rst_ni)
            (valid_o && !ready_i && !clr_i) |=>
                (valid_o && $stable(data_o) && $stable(last_o) && $stable(cnt_o));
    endproperty
    a_out_stable: assert property (p_out_stable);

    // An error pulse always follows a discarded word, so nothing is held.
    property p_err_idle;
        @(posedge clk_i) disable iff (!rst_ni)
            err_o |-> idle_o;
    endproperty
    a_err_idle: assert property (p_err_idle);

    // The counter never exceeds the number of chunks in a word.
    property p_cnt_range;
        @(posedge clk_i) disable iff (!rst_ni)
            (int'(r_cnt_q) <= Ratio);
    endproperty
    a_cnt_range: assert property (p_cnt_range);

endmodule

// File: tb/tb_prim_fifo_unpack.sv
module tb_prim_fifo_unpack;

  localparam int InW   = 32;
  localparam int OutW  = 8;
  localparam int Ratio = InW / OutW;
  localparam int CntW  = $clog2(Ratio + 1);

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             clr_i;
  logic             valid_i;
  logic             ready_o;
  logic [InW-1:0]   data_i;
  logic [Ratio-1:0] mask_i;
  logic             valid_o;
  logic             ready_i;
  logic [OutW-1:0]  data_o;
  logic             last_o;
  logic [CntW-1:0]  cnt_o;
  logic             err_o;
  logic             idle_o;

  prim_fifo_unpack #(.InW(InW), .OutW(OutW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (clr_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .mask_i  (mask_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .last_o  (last_o),
    .cnt_o   (cnt_o),
    .err_o   (err_o),
    .idle_o  (idle_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [OutW-1:0] exp_q[$];
  logic [InW-1:0]  src_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_o"}, 32'(valid_o), 32'd0);
    check({tag, "_ready_o"}, 32'(ready_o), 32'd0);
    check({tag, "_last_o"},  32'(last_o),  32'd0);
    check({tag, "_data_o"},  32'(data_o),  32'd0);
    check({tag, "_cnt_o"},   32'(cnt_o),   32'd0);
    check({tag, "_idle_o"},  32'(idle_o),  32'd1);
    check({tag, "_err_o"},   32'(err_o),   32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: inputs applied for one cycle, expected outputs in that cycle
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        clr;
    logic        vi;
    logic [31:0] di;
    logic [3:0]  mi;
    logic        ri;
    logic        vo;
    logic        ro;
    logic [7:0]  dout;
    logic        lo;
    logic [2:0]  co;
    logic        eo;
    logic        io;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic clr, logic vi, logic [31:0] di, logic [3:0] mi, logic ri,
                              logic vo, logic ro, logic [7:0] dout, logic lo, logic [2:0] co,
                              logic eo, logic io);
    vec_t v;
    v.clr = clr; v.vi = vi; v.di = di; v.mi = mi; v.ri = ri;
    v.vo = vo; v.ro = ro; v.dout = dout; v.lo = lo; v.co = co; v.eo = eo; v.io = io;
    return v;
  endfunction

  task automatic fill_table();
    //                  clr vi  di            mi     ri   vo   ro   dout   lo   co  eo   io
    // full word, LSB first
    vecs.push_back(mk(0, 1, 32'hDDCCBBAA, 4'hF, 1,  0, 1, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  1, 0, 8'hAA, 0, 4, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  1, 0, 8'hBB, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  1, 0, 8'hCC, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  1, 1, 8'hDD, 1, 1, 0, 0));
    // partial word, two chunks
    vecs.push_back(mk(0, 1, 32'h11223344, 4'h3, 1,  0, 1, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  1, 0, 8'h44, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  1, 1, 8'h33, 1, 1, 0, 0));
    // illegal masks 0000 and 0101
    vecs.push_back(mk(0, 1, 32'hCAFEF00D, 4'h0, 1,  0, 1, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 32'h12345678, 4'h5, 1,  0, 1, 8'h00, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  0, 1, 8'h00, 0, 0, 1, 1));
    // backpressure for 5 cycles after first chunk
    vecs.push_back(mk(0, 1, 32'hDDCCBBAA, 4'hF, 1,  0, 1, 8'h00, 0, 0, 0, 1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 1, 32'hDDCCBBAA, 4'hF, 0,  1, 0, 8'hAA, 0, 4, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  1, 0, 8'hAA, 0, 4, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  1, 0, 8'hBB, 0, 3, 0, 0));
    // clear with two chunks left, offered word must not be taken
    vecs.push_back(mk(1, 1, 32'h99999999, 4'hF, 1,  1, 0, 8'hCC, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  0, 1, 8'h00, 0, 0, 0, 1));
    // next word starts cleanly, then back-to-back 3-chunk word
    vecs.push_back(mk(0, 1, 32'h55667788, 4'hF, 1,  0, 1, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  1, 0, 8'h88, 0, 4, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  1, 0, 8'h77, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  1, 0, 8'h66, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 32'h04030201, 4'h7, 1,  1, 1, 8'h55, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  1, 0, 8'h01, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  1, 0, 8'h02, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  1, 1, 8'h03, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  0, 1, 8'h00, 0, 0, 0, 1));
    // illegal word offered during clear: no error pulse
    vecs.push_back(mk(1, 1, 32'h0,        4'h0, 1,  0, 0, 8'h00, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        4'h0, 1,  0, 1, 8'h00, 0, 0, 0, 1));
  endtask

  // ---------------------------------------------------------------------------
  // Driver / test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [OutW-1:0] exp_b;
    logic [InW-1:0]  w;
    int gap;
    bit started;

    clr_i = 1'b0; valid_i = 1'b0; data_i = '0; mask_i = '0; ready_i = 1'b0;
    fill_table();

    // reset state, with a word offered that must not be taken
    repeat (3) @(negedge clk);
    valid_i = 1'b1; data_i = 32'hFFFFFFFF; mask_i = 4'hF; ready_i = 1'b1;
    #1;
    check_reset_outputs("rst");

    // first cycle after release: still not ready
    @(negedge clk);
    rst_n = 1'b1;
    valid_i = 1'b0;
    #1;
    check("rel0_ready_o", 32'(ready_o), 32'd0);
    check("rel0_valid_o", 32'(valid_o), 32'd0);

    // table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      clr_i = vecs[i].clr; valid_i = vecs[i].vi; data_i = vecs[i].di;
      mask_i = vecs[i].mi; ready_i = vecs[i].ri;
      #1;
      check($sformatf("v%0d_valid_o", i), 32'(valid_o), 32'(vecs[i].vo));
      check($sformatf("v%0d_ready_o", i), 32'(ready_o), 32'(vecs[i].ro));
      check($sformatf("v%0d_last_o",  i), 32'(last_o),  32'(vecs[i].lo));
      check($sformatf("v%0d_cnt_o",   i), 32'(cnt_o),   32'(vecs[i].co));
      check($sformatf("v%0d_err_o",   i), 32'(err_o),   32'(vecs[i].eo));
      check($sformatf("v%0d_idle_o",  i), 32'(idle_o),  32'(vecs[i].io));
      if (vecs[i].vo)
        check($sformatf("v%0d_data_o", i), 32'(data_o), 32'(vecs[i].dout));
    end
    clr_i = 1'b0;

    // two back-to-back full words from a FIFO-like source
    src_q.push_back(32'h44332211);
    src_q.push_back(32'h88776655);
    for (int b = 1; b <= 8; b++) exp_q.push_back(8'(b * 8'h11));
    gap = 0;
    started = 1'b0;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      valid_i = (src_q.size() > 0);
      w = (src_q.size() > 0) ? src_q[0] : '0;
      data_i = w; mask_i = 4'hF; ready_i = 1'b1;
      #1;
      if (valid_o) begin
        started = 1'b1;
        exp_b = exp_q.pop_front();
        check("stream_data", 32'(data_o), 32'(exp_b));
      end else if (started) begin
        gap++;
      end
      if (valid_i && ready_o) void'(src_q.pop_front());
    end
    check("stream_left", 32'(exp_q.size()), 32'd0);
    check("stream_gap", 32'(gap), 32'd0);

    // reset mid-word
    @(negedge clk);
    valid_i = 1'b1; data_i = 32'hA1B2C3D4; mask_i = 4'hF; ready_i = 1'b1;
    #1;
    check("mid_ready_o", 32'(ready_o), 32'd1);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    check("mid_chunk0", 32'(data_o), 32'hD4);
    @(negedge clk);
    #1;
    check("mid_chunk1", 32'(data_o), 32'hC3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    valid_i = 1'b1; data_i = 32'h0; mask_i = 4'hF;
    #1;
    check("rel1_ready_o", 32'(ready_o), 32'd0);
    check("rel1_valid_o", 32'(valid_o), 32'd0);
    @(negedge clk);
    #1;
    check("rel2_ready_o", 32'(ready_o), 32'd1);
    check("rel2_valid_o", 32'(valid_o), 32'd0);
    check("rel2_cnt_o",   32'(cnt_o),   32'd0);
    valid_i = 1'b0;
    @(negedge clk);
    #1;
    check("rel3_valid_o", 32'(valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
